// File: rtl/lp805x_cntfilter_pkg.sv
// Shared SFR defines for the lp805x count-pin filter.
//   - SFR byte addresses FLTCTR / FLTCNT / FLTSTA
//   - FLTCTR and FLTSTA field positions
//   - edge-select and sample-divider encodings
//   - div_mask(): prescaler bits that must all be 1 for a sample tick
package lp805x_cntfilter_pkg;

    localparam logic [7:0] FLTCTR_ADDR = 8'hEC;
    localparam logic [7:0] FLTCNT_ADDR = 8'hED;
    localparam logic [7:0] FLTSTA_ADDR = 8'hEE;

    // FLTCTR field positions
    localparam int CTR_EN      = 7;
    localparam int CTR_EDGE_HI = 6;
    localparam int CTR_EDGE_LO = 5;
    localparam int CTR_INV     = 4;
    localparam int CTR_DIV_HI  = 3;
    localparam int CTR_DIV_LO  = 2;
    localparam int CTR_IE      = 1;

    // FLTSTA field positions
    localparam int STA_OVF  = 0;
    localparam int STA_FLEV = 1;

    typedef enum logic [1:0] {
        EDGE_FALL = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_NONE = 2'b11
    } edge_sel_e;

    typedef enum logic [1:0] {
        DIV_1  = 2'b00,
        DIV_4  = 2'b01,
        DIV_16 = 2'b10,
        DIV_64 = 2'b11
    } div_sel_e;

    // A tick fires when every prescaler bit covered by the mask is 1,
    // i.e. once per 1, 4, 16 or 64 clocks.
    function automatic logic [5:0] div_mask(input div_sel_e d);
        case (d)
            DIV_1:   div_mask = 6'h00;
            DIV_4:   div_mask = 6'h03;
            DIV_16:  div_mask = 6'h0F;
            default: div_mask = 6'h3F;
        endcase
    endfunction

endpackage

// File: rtl/lp805x_cntfilter_sync.sv
// lp805x_sync: multi-flop synchronizer for an asynchronous single-bit input.
//   clk   in  1  destination clock
//   rst   in  1  asynchronous active-high reset, clears every stage to 0
//   d     in  1  asynchronous input
//   q     out 1  synchronized output, STAGES clocks of latency
// STAGES must be at least 2.
module lp805x_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= '0;
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/lp805x_cntfilter.sv
// lp805x_cntfilter: glitch filter and edge counter for an external count pin.
// The pin is synchronized, optionally inverted, sampled on a prescaled tick
// and must be stable for 3 consecutive samples before the filtered level
// (flev) follows it. Qualified flev edges pulse cnt_out for one clock and
// bump FLTCNT; FLTCNT wrapping sets the sticky STA.ovf bit.
//   clk, rst                     clock, asynchronous active-high reset
//   wr, wr_bit, wr_addr, data_in SFR byte write (wr_bit=1 writes ignored)
//   rd, rd_bit, rd_addr          SFR read (decoded on rd_addr alone)
//   bit_in                       unused bit-write data
//   data_out                     read data, 1 clk latency, hi-Z when unselected
//   bit_out                      constant hi-Z
//   pin_raw                      asynchronous count pin
//   cnt_out                      one-clock conditioned count pulse
//   flt_irq                      STA.ovf AND CTR.ie
module lp805x_cntfilter
    import lp805x_cntfilter_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CNT_RSTVAL  = 8'h00,
    parameter logic [7:0] CTR_RSTVAL  = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic       wr_bit,
    input  logic       rd,
    input  logic       rd_bit,
    input  logic [7:0] wr_addr,
    input  logic [7:0] rd_addr,
    input  logic [7:0] data_in,
    input  logic       bit_in,
    output logic [7:0] data_out,
    output logic       bit_out,
    input  logic       pin_raw,
    output logic       cnt_out,
    output logic       flt_irq
);

    logic [7:0] ctr;
    logic [7:0] cnt;
    logic       ovf;
    logic       sync_q;
    logic       s;
    logic [5:0] psc;
    div_sel_e   div_act;
    logic       tick;
    logic [1:0] hist;
    logic       flev;
    logic       flev_d;
    logic       edge_hit;
    logic       wr_ctr, wr_cnt, wr_sta;
    logic       ovf_set, ovf_clr;
    logic [7:0] rd_mux;
    logic       rd_sel;
    logic [7:0] rd_val;
    logic       rd_flag;

    logic       ctr_en;
    edge_sel_e  ctr_edge;
    div_sel_e   ctr_div;

    // Read strobes carry no meaning here: reads decode on rd_addr alone.
    wire unused_ok = &{1'b0, rd, rd_bit, bit_in};

    assign ctr_en   = ctr[CTR_EN];
    assign ctr_edge = edge_sel_e'(ctr[CTR_EDGE_HI:CTR_EDGE_LO]);
    assign ctr_div  = div_sel_e'(ctr[CTR_DIV_HI:CTR_DIV_LO]);

    assign wr_ctr = wr && !wr_bit && (wr_addr == FLTCTR_ADDR);
    assign wr_cnt = wr && !wr_bit && (wr_addr == FLTCNT_ADDR);
    assign wr_sta = wr && !wr_bit && (wr_addr == FLTSTA_ADDR);

    lp805x_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pin_raw),
        .q   (sync_q)
    );

    assign s = sync_q ^ ctr[CTR_INV];

    // Prescaler. The active divider is only swapped at a prescaler wrap so a
    // mid-period divider change never produces a short sample interval.
    assign tick = ctr_en && ((psc | ~div_mask(div_act)) == 6'h3F);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc     <= '0;
            div_act <= div_sel_e'(CTR_RSTVAL[CTR_DIV_HI:CTR_DIV_LO]);
        end else if (!ctr_en) begin
            psc     <= '0;
            div_act <= ctr_div;
        end else begin
            psc <= psc + 6'd1;
            if (psc == 6'h3F) div_act <= ctr_div;
        end
    end

    // Filter. While disabled, history and both flev copies track s directly
    // so that enabling can never expose a stale level as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist   <= '0;
            flev   <= 1'b0;
            flev_d <= 1'b0;
        end else if (!ctr_en) begin
            hist   <= {s, s};
            flev   <= s;
            flev_d <= s;
        end else begin
            flev_d <= flev;
            if (tick) begin
                hist <= {hist[0], s};
                if ((s == hist[0]) && (s == hist[1]) && (s != flev)) flev <= s;
            end
        end
    end

    // flev changed at the previous edge and flev_d still holds the old level.
    always_comb begin
        edge_hit = 1'b0;
        case (ctr_edge)
            EDGE_FALL: edge_hit = !flev &&  flev_d;
            EDGE_RISE: edge_hit =  flev && !flev_d;
            EDGE_BOTH: edge_hit =  flev !=  flev_d;
            default:   edge_hit = 1'b0;
        endcase
        edge_hit = edge_hit && ctr_en;
    end

    // A CPU write to FLTCNT takes the cycle; a coincident edge neither
    // increments nor wraps.
    assign ovf_set = edge_hit && !wr_cnt && (cnt == 8'hFF);
    assign ovf_clr = wr_sta && data_in[STA_OVF];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr     <= CTR_RSTVAL & 8'hFE;
            cnt     <= CNT_RSTVAL;
            ovf     <= 1'b0;
            cnt_out <= 1'b0;
        end else begin
            cnt_out <= edge_hit;
            if (wr_ctr) ctr <= {data_in[7:1], 1'b0};
            if (wr_cnt)        cnt <= data_in;
            else if (edge_hit) cnt <= cnt + 8'd1;
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    // Read path: one register stage, driven only when an SFR matched.
    always_comb begin
        rd_mux = 8'h00;
        rd_sel = 1'b0;
        case (rd_addr)
            FLTCTR_ADDR: begin rd_mux = ctr; rd_sel = 1'b1; end
            FLTCNT_ADDR: begin rd_mux = cnt; rd_sel = 1'b1; end
            FLTSTA_ADDR: begin rd_mux = {6'b0, flev, ovf}; rd_sel = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_val  <= 8'h00;
            rd_flag <= 1'b0;
        end else begin
            rd_val  <= rd_mux;
            rd_flag <= rd_sel;
        end
    end

    assign data_out = rd_flag ? rd_val : 8'hzz;
    assign bit_out  = 1'bz;
    assign flt_irq  = ovf && ctr[CTR_IE];

endmodule

// File: tb/tb_lp805x_cntfilter.sv
// Self-checking bench for lp805x_cntfilter: table-driven SFR and pin
// vectors plus hand-written multi-cycle sequences.
module tb_lp805x_cntfilter;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr, wr_bit, rd, rd_bit, bit_in, pin_raw;
    logic [7:0] wr_addr, rd_addr, data_in;
    wire  [7:0] data_out;
    wire        bit_out;
    wire        cnt_out;
    wire        flt_irq;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic pin;
        logic exp_cnt;
    } pin_vec_t;

    typedef struct {
        logic       wbit;
        logic [7:0] waddr;
        logic [7:0] wdata;
        logic [7:0] raddr;
        logic [7:0] exp;
    } sfr_vec_t;

    pin_vec_t pv[37];
    sfr_vec_t sv[8];

    lp805x_cntfilter dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .wr_bit   (wr_bit),
        .rd       (rd),
        .rd_bit   (rd_bit),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .data_in  (data_in),
        .bit_in   (bit_in),
        .data_out (data_out),
        .bit_out  (bit_out),
        .pin_raw  (pin_raw),
        .cnt_out  (cnt_out),
        .flt_irq  (flt_irq)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- drivers (called and returning at a negedge) ----------------
    task automatic sfr_write(input logic [7:0] a, input logic [7:0] d, input logic b);
        wr = 1'b1; wr_bit = b; wr_addr = a; data_in = d;
        @(negedge clk);
        wr = 1'b0; wr_bit = 1'b0;
    endtask

    task automatic sfr_read(input logic [7:0] a, output logic [7:0] d);
        rd_addr = a; rd = 1'b1;
        @(negedge clk);
        d = data_out;
        rd = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] got;
        exp_q.push_back(exp);
        sfr_read(a, got);
        check(name, got, exp_q.pop_front());
    endtask

    // Each row: compare cnt_out (state after the previous edge), then drive pin.
    task automatic run_pins(input int lo, input int hi, input string name);
        for (int i = lo; i <= hi; i++) begin
            check($sformatf("%s[%0d] cnt_out", name, i - lo), {7'b0, cnt_out}, {7'b0, pv[i].exp_cnt});
            pin_raw = pv[i].pin;
            @(negedge clk);
        end
    endtask

    task automatic count_pulses(input int n, output int pulses, output int last_at);
        pulses  = 0;
        last_at = -1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (cnt_out === 1'b1) begin
                pulses++;
                last_at = c;
            end
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int pulses, pulse_at, dummy_at;

        // pin table A: falling edge, pin drops at row 6 -> pulse checked at row 12
        for (int i = 0; i < 15; i++) begin
            pv[i].pin     = (i < 6);
            pv[i].exp_cnt = (i == 12);
        end
        // pin table B: rising only; 2-clk glitch at rows 0-1, 3-clk pulse at
        // rows 10-12 -> pulse at row 16, its falling edge (row 19) not counted
        for (int b = 0; b < 22; b++) begin
            pv[15 + b].pin     = (b < 2) || (b >= 10 && b < 13);
            pv[15 + b].exp_cnt = (b == 16);
        end
        // SFR table
        sv[0] = '{1'b0, 8'hEC, 8'h6F, 8'hEC, 8'h6E};
        sv[1] = '{1'b1, 8'hEC, 8'hFF, 8'hEC, 8'h6E};
        sv[2] = '{1'b0, 8'hED, 8'hA5, 8'hED, 8'hA5};
        sv[3] = '{1'b1, 8'hED, 8'h3C, 8'hED, 8'hA5};
        sv[4] = '{1'b0, 8'hEF, 8'h12, 8'hED, 8'hA5};
        sv[5] = '{1'b0, 8'hEE, 8'hFF, 8'hEE, 8'h00};
        sv[6] = '{1'b0, 8'hEC, 8'h00, 8'hEC, 8'h00};
        sv[7] = '{1'b0, 8'hED, 8'h00, 8'hED, 8'h00};

        rst = 1'b1; wr = 1'b0; wr_bit = 1'b0; rd = 1'b0; rd_bit = 1'b0; bit_in = 1'b0;
        pin_raw = 1'b0; wr_addr = 8'h00; rd_addr = 8'h00; data_in = 8'h00;
        repeat (3) @(negedge clk);
        check("rst cnt_out", {7'b0, cnt_out}, 8'h00);
        check("rst flt_irq", {7'b0, flt_irq}, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        read_check("rst CTR", 8'hEC, 8'h00);
        read_check("rst CNT", 8'hED, 8'h00);
        read_check("rst STA", 8'hEE, 8'h00);

        // SFR access table
        for (int i = 0; i < 8; i++) begin
            sfr_write(sv[i].waddr, sv[i].wdata, sv[i].wbit);
            read_check($sformatf("sfr[%0d]", i), sv[i].raddr, sv[i].exp);
        end

        // A: falling edge timing
        pin_raw = 1'b1;
        repeat (6) @(negedge clk);
        sfr_write(8'hEC, 8'h80, 1'b0);
        run_pins(0, 14, "fall");
        read_check("fall CNT", 8'hED, 8'h01);

        // B: glitch rejection and 3-sample pulse
        sfr_write(8'hEC, 8'hA0, 1'b0);
        run_pins(15, 36, "glitch");
        read_check("glitch CNT", 8'hED, 8'h02);

        // C: both edges, wrap to ovf, irq, ovf clear
        sfr_write(8'hEC, 8'hC2, 1'b0);
        sfr_write(8'hED, 8'hFE, 1'b0);
        pin_raw = 1'b1; repeat (10) @(negedge clk);
        pin_raw = 1'b0; repeat (10) @(negedge clk);
        read_check("wrap CNT", 8'hED, 8'h00);
        read_check("wrap STA", 8'hEE, 8'h01);
        check("wrap flt_irq", {7'b0, flt_irq}, 8'h01);
        sfr_write(8'hEE, 8'h00, 1'b0);
        read_check("sta wr0 STA", 8'hEE, 8'h01);
        sfr_write(8'hEE, 8'h01, 1'b1);
        read_check("sta bitwr STA", 8'hEE, 8'h01);
        sfr_write(8'hEE, 8'h01, 1'b0);
        read_check("sta clr STA", 8'hEE, 8'h00);
        check("sta clr flt_irq", {7'b0, flt_irq}, 8'h00);

        // D1: CPU write to FLTCNT coincident with the increment edge
        pin_raw = 1'b1;
        repeat (5) @(negedge clk);
        sfr_write(8'hED, 8'h55, 1'b0);
        read_check("wr vs inc CNT", 8'hED, 8'h55);
        // D2: ovf clear coincident with wrap
        sfr_write(8'hED, 8'hFF, 1'b0);
        pin_raw = 1'b0;
        repeat (5) @(negedge clk);
        sfr_write(8'hEE, 8'h01, 1'b0);
        read_check("set vs clr CNT", 8'hED, 8'h00);
        read_check("set vs clr STA", 8'hEE, 8'h01);
        check("set vs clr flt_irq", {7'b0, flt_irq}, 8'h01);

        // E: /64 divider; enabling zeroes the prescaler so the third sample
        // lands 192 clocks after the enable write, pulse one clock later
        sfr_write(8'hEE, 8'h01, 1'b0);
        sfr_write(8'hEC, 8'h4C, 1'b0);
        repeat (4) @(negedge clk);
        sfr_write(8'hEC, 8'hCC, 1'b0);
        pin_raw = 1'b1;
        count_pulses(260, pulses, pulse_at);
        check("div64 pulses", pulses[7:0], 8'd1);
        check("div64 pulse_at", pulse_at[7:0], 8'd193);
        read_check("div64 STA", 8'hEE, 8'h02);
        pulses = 0;
        for (int t = 0; t < 6; t++) begin
            int p;
            pin_raw = ~pin_raw;
            count_pulses(100, p, dummy_at);
            pulses += p;
        end
        check("div64 toggle100 pulses", pulses[7:0], 8'd0);

        // F: enable with pin low after disable -> no spurious pulse
        sfr_write(8'hEC, 8'h40, 1'b0);
        pin_raw = 1'b0;
        repeat (5) @(negedge clk);
        sfr_write(8'hEC, 8'hC0, 1'b0);
        count_pulses(20, pulses, dummy_at);
        check("enable pulses", pulses[7:0], 8'd0);

        // reset during a cnt_out pulse
        pin_raw = 1'b1;
        repeat (6) @(negedge clk);
        check("pre-rst cnt_out", {7'b0, cnt_out}, 8'h01);
        rst = 1'b1; pin_raw = 1'b0;
        #1;
        check("mid-rst cnt_out", {7'b0, cnt_out}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        read_check("post-rst CTR", 8'hEC, 8'h00);
        read_check("post-rst CNT", 8'hED, 8'h00);
        read_check("post-rst STA", 8'hEE, 8'h00);
        check("post-rst flt_irq", {7'b0, flt_irq}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
